feedback_echo: RTL and testbench

FEEDBACK_ECHO -- requirements
Module: feedback_echo

---
 rtl/feedback_echo_pkg.sv | 35 +++
 rtl/echo_ram.sv | 31 +++
 rtl/feedback_echo.sv | 184 ++++++++++++++++++
 tb/tb_feedback_echo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/feedback_echo_pkg.sv
// Shared types and helpers for the feedback_echo delay-line effect.
// FSM state encoding plus a width-parameterised signed saturation function.
package feedback_echo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CALC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Working width for saturating arithmetic; callers sign-extend into it.
  localparam int unsigned SAT_W = 64;

  // Clamp v to the signed range of a w-bit word (w <= SAT_W-1).
  function automatic logic signed [SAT_W-1:0] sat_fn(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = ~hi;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/echo_ram.sv
// Delay-line storage: SIZE x DATA_WIDTH simple dual-port RAM.
// Synchronous write, registered read, array deliberately not reset.
module echo_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE       = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [SIZE];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/feedback_echo.sv
// Echo effect: y = sat(x + mix*delayed), one sample per 4-cycle IDLE/READ/CALC/WRITE pass.
// Define FEEDBACK_ECHO_FEEDBACK_EN to write sat(x + fb*delayed) back (IIR); default writes x (FIR).
module feedback_echo
  import feedback_echo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE       = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned GAIN_WIDTH = 8
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic                         x_valid,
  output logic                         x_ready,
  input  logic                         en,
  input  logic        [ADDR_WIDTH-1:0] delay_len,
  input  logic        [GAIN_WIDTH-1:0] mix_gain,
  input  logic        [GAIN_WIDTH-1:0] fb_gain,
  output logic signed [DATA_WIDTH-1:0] y,
  output logic                         y_valid
);

  localparam int unsigned           PW     = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   SIZE_W = (ADDR_WIDTH + 1)'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(SIZE - 1);

  state_t state_q, state_d;
  logic   accept;
  logic   ram_we, ram_re;

  logic signed [DATA_WIDTH-1:0] x_q;
  logic                         en_q;
  logic        [ADDR_WIDTH-1:0] dlen_q;
  logic        [GAIN_WIDTH-1:0] mix_q;
  logic        [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic        [ADDR_WIDTH:0]   addr_wide;
  logic        [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic        [ADDR_WIDTH:0]   fill_q, fill_d;
  logic        [DATA_WIDTH-1:0] ram_rdata;

  logic signed [DATA_WIDTH-1:0] d, m, y_calc, w_calc;
  logic signed [PW-1:0]         prod_m;
  logic signed [DATA_WIDTH-1:0] y_q, w_q;
  logic                         y_valid_q;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (x_valid) state_d = READ;
      READ:    state_d = CALC;
      CALC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_ready = (state_q == IDLE);
    ram_re  = (state_q == READ);
    ram_we  = (state_q == WRITE) && en_q;
  end

  assign accept = x_valid && x_ready;

  // Read address wraps modulo SIZE even when SIZE is not a power of two.
  always_comb begin
    addr_wide = {1'b0, wr_ptr_q} + SIZE_W - {1'b0, delay_len};
    if (addr_wide >= SIZE_W) begin
      addr_wide = addr_wide - SIZE_W;
    end
    rd_addr_d = ADDR_WIDTH'(addr_wide);
  end

  always_comb begin
    wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    fill_d   = (fill_q == SIZE_W) ? fill_q : fill_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      x_q       <= '0;
      en_q      <= 1'b0;
      dlen_q    <= '0;
      mix_q     <= '0;
      rd_addr_q <= '0;
    end else if (accept) begin
      x_q       <= x;
      en_q      <= en;
      dlen_q    <= delay_len;
      mix_q     <= mix_gain;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (ram_we) begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Locations not yet written since reset read as silence.
  always_comb begin
    d = ((dlen_q == '0) || (fill_q < {1'b0, dlen_q})) ? '0 : signed'(ram_rdata);
    prod_m = PW'(d) * PW'(signed'({1'b0, mix_q}));
    m      = DATA_WIDTH'(prod_m >>> GAIN_WIDTH);
    if (en_q) begin
      y_calc = DATA_WIDTH'(sat_fn(SAT_W'(x_q) + SAT_W'(m), DATA_WIDTH));
    end else begin
      y_calc = x_q;
    end
  end

`ifdef FEEDBACK_ECHO_FEEDBACK_EN
  logic        [GAIN_WIDTH-1:0] fb_q;
  logic signed [PW-1:0]         prod_f;
  logic signed [DATA_WIDTH-1:0] f;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      fb_q <= '0;
    end else if (accept) begin
      fb_q <= fb_gain;
    end
  end

  always_comb begin
    prod_f = PW'(d) * PW'(signed'({1'b0, fb_q}));
    f      = DATA_WIDTH'(prod_f >>> GAIN_WIDTH);
    w_calc = DATA_WIDTH'(sat_fn(SAT_W'(x_q) + SAT_W'(f), DATA_WIDTH));
  end
`else
  logic unused_fb;
  assign unused_fb = ^fb_gain;

  always_comb begin
    w_calc = x_q;
  end
`endif

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      y_q       <= '0;
      w_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= (state_q == CALC);
      if (state_q == CALC) begin
        y_q <= y_calc;
        w_q <= w_calc;
      end
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;

  echo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .SIZE      (SIZE),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (CLK),
    .we_i   (ram_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(w_q),
    .re_i   (ram_re),
    .raddr_i(rd_addr_q),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_feedback_echo.sv
// Directed self-checking bench for feedback_echo (default parameters).
// Expected echo values follow the build: FEEDBACK_ECHO_FEEDBACK_EN selects IIR expectations.
module tb_feedback_echo;

  logic               CLK = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] x = '0;
  logic               x_valid = 1'b0;
  logic               x_ready;
  logic               en = 1'b1;
  logic        [2:0]  delay_len = '0;
  logic        [7:0]  mix_gain = '0;
  logic        [7:0]  fb_gain = '0;
  logic signed [31:0] y;
  logic               y_valid;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_yv     = 0;

  always #5 CLK = ~CLK;

  feedback_echo #(
    .DATA_WIDTH(32),
    .SIZE      (8),
    .ADDR_WIDTH(3),
    .GAIN_WIDTH(8)
  ) dut (
    .CLK      (CLK),
    .rst      (rst),
    .x        (x),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .en       (en),
    .delay_len(delay_len),
    .mix_gain (mix_gain),
    .fb_gain  (fb_gain),
    .y        (y),
    .y_valid  (y_valid)
  );

  always @(negedge CLK) if (y_valid) n_yv++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst = 1'b0;
    repeat (2) @(negedge CLK);
    rst = 1'b1;
  endtask

  // One sample: inputs are scrambled right after accept to show they were captured.
  task automatic send(input logic signed [31:0] xv, input logic signed [31:0] yexp, input string tag);
    int unsigned t;
    int unsigned lat;
    logic        se;
    logic [2:0]  sd;
    logic [7:0]  sm, sf;
    t = 0;
    @(negedge CLK);
    while (!x_ready && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check({tag, " ready"}, 64'(x_ready), 64'd1);
    x = xv;
    x_valid = 1'b1;
    @(posedge CLK);
    #1;
    x_valid = 1'b0;
    se = en; sd = delay_len; sm = mix_gain; sf = fb_gain;
    x = $urandom;
    en = ~se; delay_len = ~sd; mix_gain = ~sm; fb_gain = ~sf;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!y_valid && lat < 10);
    check({tag, " latency"}, 64'(lat), 64'd3);
    check(tag, 64'(y), 64'(yexp));
    @(negedge CLK);
    check({tag, " pulse"}, 64'(y_valid), 64'd0);
    en = se; delay_len = sd; mix_gain = sm; fb_gain = sf;
  endtask

  initial begin : stim
    int          imp_fir [9];
    int          imp_fb  [10];
    int unsigned acc_cnt, first_acc, last_acc, yv_snap;
    string       s;

    imp_fir = '{1000, 0, 0, 500, 0, 0, 0, 0, 0};
`ifdef FEEDBACK_ECHO_FEEDBACK_EN
    imp_fb  = '{1024, 0, 0, 512, 0, 0, 256, 0, 0, 128};
`else
    imp_fb  = '{1024, 0, 0, 512, 0, 0, 0, 0, 0, 0};
`endif

    #2 rst = 1'b0;
    #1;
    check("rst x_ready", 64'(x_ready), 64'd1);
    check("rst y", 64'(y), 64'd0);
    check("rst y_valid", 64'(y_valid), 64'd0);
    #20 rst = 1'b1;

    // Single FIR echo of an impulse, no feedback.
    en = 1'b1; delay_len = 3'd3; mix_gain = 8'd128; fb_gain = 8'd0;
    for (int i = 0; i < 9; i++) begin
      s = $sformatf("imp_fir[%0d]", i);
      send((i == 0) ? 32'sd1000 : 32'sd0, imp_fir[i], s);
    end

    // Recirculating echo (FIR build shows only the first echo).
    do_reset();
    delay_len = 3'd3; mix_gain = 8'd128; fb_gain = 8'd128;
    for (int i = 0; i < 10; i++) begin
      s = $sformatf("imp_fb[%0d]", i);
      send((i == 0) ? 32'sd1024 : 32'sd0, imp_fb[i], s);
    end

    // Saturation at both rails.
    do_reset();
    delay_len = 3'd1; mix_gain = 8'd255; fb_gain = 8'd0;
    send(32'sh7FFFFFF0, 32'sh7FFFFFF0, "sat_pos[0]");
    send(32'sh7FFFFFF0, 32'sh7FFFFFFF, "sat_pos[1]");
    send(32'sh7FFFFFF0, 32'sh7FFFFFFF, "sat_pos[2]");
    do_reset();
    send(32'sh80000010, 32'sh80000010, "sat_neg[0]");
    send(32'sh80000010, 32'sh80000000, "sat_neg[1]");
    send(32'sh80000010, 32'sh80000000, "sat_neg[2]");

    // Bypass must not write or advance; delay_len 0 mutes the echo.
    do_reset();
    delay_len = 3'd1; mix_gain = 8'd128;
    send(32'sd400, 32'sd400, "byp pre");
    en = 1'b0;
    send(32'sd9000, 32'sd9000, "byp pass");
    en = 1'b1;
    send(32'sd0, 32'sd200, "byp after");
    delay_len = 3'd0;
    send(32'sd50, 32'sd50, "mute");

    // Ramp through two pointer wraps.
    do_reset();
    delay_len = 3'd7; mix_gain = 8'd128;
    for (int k = 1; k <= 20; k++) begin
      s = $sformatf("ramp[%0d]", k);
      send(k, (k <= 7) ? k : k + ((k - 7) >>> 1), s);
    end

    // Continuous x_valid: accepts spaced four cycles apart.
    do_reset();
    x = 32'sd0;
    acc_cnt = 0; first_acc = 0; last_acc = 0;
    @(negedge CLK);
    x_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      if (x_ready) begin
        if (acc_cnt == 0) first_acc = c;
        last_acc = c;
        acc_cnt++;
      end
    end
    x_valid = 1'b0;
    check("stream accepts", 64'(acc_cnt), 64'd4);
    check("stream spacing", 64'(last_acc - first_acc), 64'd12);
    repeat (6) @(negedge CLK);

    // Reset while in CALC aborts the sample.
    delay_len = 3'd1; mix_gain = 8'd128;
    @(negedge CLK);
    x = 32'sd3000;
    x_valid = 1'b1;
    @(posedge CLK);
    #1 x_valid = 1'b0;
    yv_snap = n_yv;
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    #1;
    check("abort x_ready", 64'(x_ready), 64'd1);
    check("abort y", 64'(y), 64'd0);
    check("abort y_valid", 64'(y_valid), 64'd0);
    repeat (3) @(negedge CLK);
    rst = 1'b1;
    repeat (4) @(negedge CLK);
    check("abort no pulse", 64'(n_yv), 64'(yv_snap));
    send(32'sd0, 32'sd0, "no stale[0]");
    send(32'sd0, 32'sd0, "no stale[1]");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
